// File: rtl/timer_pkg.sv
// Shared types and constants for the lap timer bank: command codes, channel states,
// count width and the length of a day in centiseconds.
package timer_pkg;

    localparam int CS_W   = 24;
    localparam int DAY_CS = 8640000;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_START = 3'd1,
        OP_STOP  = 3'd2,
        OP_LAP   = 3'd3,
        OP_CLEAR = 3'd4
    } cmdOp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } chState_t;

    function automatic logic [CS_W-1:0] clampCs(input logic [CS_W-1:0] value);
        return (value > CS_W'(DAY_CS - 1)) ? CS_W'(DAY_CS - 1) : value;
    endfunction

endpackage

// File: rtl/lap_fifo.sv
// First-word-fall-through FIFO holding captured lap records; headData is valid
// whenever empty is low. Pointers carry one extra wrap bit to tell full from empty.
module lap_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clockSignal,
    input  logic             startOrStop,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             pushOk;
    logic             popOk;

    assign count  = wrPtr - rdPtr;
    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign popOk  = pop && !empty;
    // A pop frees the slot this same edge, so a full FIFO can still take a push.
    assign pushOk = push && (!full || popOk);

    always_ff @(posedge clockSignal or posedge startOrStop) begin
        if (startOrStop) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + (AW+1)'(1);
            if (popOk)  rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clockSignal) begin
        if (pushOk) mem[wrPtr[AW-1:0]] <= pushData;
    end

    assign headData = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/lap_timer_bank.sv
// Bank of centisecond stopwatch/countdown channels sharing one tick prescaler,
// with a lap-capture FIFO and a registered h:m:s.cs display of one channel.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | loaded or cleared, count frozen, waiting for START
// ST_RUN   | count moves one step per tick (up wraps, down stops at 0)
// ST_PAUSE | stopped by STOP, count frozen, START resumes
// ST_DONE  | countdown reached zero, expired set, only LOAD/CLEAR leave
module lap_timer_bank
    import timer_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int LAP_DEPTH = 8,
    parameter int TICK_DIV  = 1,
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clockSignal,
    input  logic                startOrStop,
    input  logic                cmd_valid,
    input  logic [2:0]          cmd_op,
    input  logic [CH_W-1:0]     cmd_ch,
    input  logic [CS_W-1:0]     load_cs,
    input  logic                load_down,
    input  logic [CH_W-1:0]     disp_ch,
    output logic [4:0]          disp_hours,
    output logic [5:0]          disp_min,
    output logic [5:0]          disp_sec,
    output logic [6:0]          disp_cs,
    output logic [CHANNELS-1:0] expired,
    output logic                lap_valid,
    output logic [CH_W-1:0]     lap_ch,
    output logic [CS_W-1:0]     lap_cs,
    input  logic                lap_ready,
    output logic                lap_overflow
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LAP_W = CH_W + CS_W;
    localparam int LAP_AW = $clog2(LAP_DEPTH);

    logic [PRE_W-1:0] preCnt;
    logic             tick;
    logic [CS_W-1:0]  count [CHANNELS];
    logic             dir [CHANNELS];
    chState_t         chState [CHANNELS];
    logic             cmdLive;
    cmdOp_t           op;
    logic             lapPush;
    logic             lapPop;
    logic [LAP_W-1:0] lapHead;
    logic             lapFull;
    logic             lapEmpty;
    logic [LAP_AW:0]  lapCount;
    logic [CS_W-1:0]  dispSel;

    assign tick = (preCnt == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clockSignal or posedge startOrStop) begin
        if (startOrStop)  preCnt <= '0;
        else if (tick)    preCnt <= '0;
        else              preCnt <= preCnt + PRE_W'(1);
    end

    assign op      = cmdOp_t'(cmd_op);
    assign cmdLive = cmd_valid && (int'(cmd_ch) < CHANNELS) && (cmd_op <= 3'd4);

    // A command on a channel takes that channel's edge; its tick is simply lost.
    always_ff @(posedge clockSignal or posedge startOrStop) begin
        if (startOrStop) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count[i]   <= '0;
                dir[i]     <= 1'b0;
                chState[i] <= ST_IDLE;
            end
            expired <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (cmdLive && int'(cmd_ch) == i) begin
                    case (op)
                        OP_LOAD: begin
                            count[i]   <= clampCs(load_cs);
                            dir[i]     <= load_down;
                            chState[i] <= ST_IDLE;
                            expired[i] <= 1'b0;
                        end
                        OP_START: if (chState[i] == ST_IDLE || chState[i] == ST_PAUSE) chState[i] <= ST_RUN;
                        OP_STOP:  if (chState[i] == ST_RUN) chState[i] <= ST_PAUSE;
                        OP_CLEAR: begin
                            count[i]   <= '0;
                            dir[i]     <= 1'b0;
                            chState[i] <= ST_IDLE;
                            expired[i] <= 1'b0;
                        end
                        default: ;
                    endcase
                end else if (chState[i] == ST_RUN) begin
                    if (dir[i] && count[i] == '0) begin
                        chState[i] <= ST_DONE;
                        expired[i] <= 1'b1;
                    end else if (tick) begin
                        if (dir[i]) begin
                            count[i] <= count[i] - CS_W'(1);
                            if (count[i] == CS_W'(1)) begin
                                chState[i] <= ST_DONE;
                                expired[i] <= 1'b1;
                            end
                        end else begin
                            count[i] <= (count[i] == CS_W'(DAY_CS - 1)) ? '0 : count[i] + CS_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign lapPush = cmdLive && (op == OP_LAP) &&
                     (chState[cmd_ch] == ST_RUN || chState[cmd_ch] == ST_PAUSE);
    assign lapPop  = lap_ready && !lapEmpty;

    lap_fifo #(
        .WIDTH (LAP_W),
        .DEPTH (LAP_DEPTH)
    ) uLapFifo (
        .clockSignal (clockSignal),
        .startOrStop (startOrStop),
        .push        (lapPush),
        .pushData    ({cmd_ch, count[cmd_ch]}),
        .pop         (lapPop),
        .headData    (lapHead),
        .full        (lapFull),
        .empty       (lapEmpty),
        .count       (lapCount)
    );

    assign lap_valid        = (lapCount != '0);
    assign {lap_ch, lap_cs} = lapEmpty ? LAP_W'(0) : lapHead;

    always_ff @(posedge clockSignal or posedge startOrStop) begin
        if (startOrStop)                        lap_overflow <= 1'b0;
        else if (lapPush && lapFull && !lapPop) lap_overflow <= 1'b1;
    end

    always_comb begin
        dispSel = '0;
        if (int'(disp_ch) < CHANNELS) dispSel = count[disp_ch];
    end

    // Constant divisors on the single selected channel; one register stage of latency.
    always_ff @(posedge clockSignal or posedge startOrStop) begin
        if (startOrStop) begin
            disp_hours <= '0;
            disp_min   <= '0;
            disp_sec   <= '0;
            disp_cs    <= '0;
        end else begin
            disp_hours <= 5'(dispSel / CS_W'(360000));
            disp_min   <= 6'((dispSel / CS_W'(6000)) % CS_W'(60));
            disp_sec   <= 6'((dispSel / CS_W'(100)) % CS_W'(60));
            disp_cs    <= 7'(dispSel % CS_W'(100));
        end
    end

endmodule

// File: tb/tb_lap_timer_bank.sv
// Directed bench for lap_timer_bank: dutA runs one tick per clock, dutB divides by 3
// and shares every input so the prescaler phase can be observed.
module tb_lap_timer_bank;

    logic        clockSignal = 1'b0;
    logic        startOrStop = 1'b1;
    logic        cmd_valid   = 1'b0;
    logic [2:0]  cmd_op      = 3'd0;
    logic [1:0]  cmd_ch      = 2'd0;
    logic [23:0] load_cs     = 24'd0;
    logic        load_down   = 1'b0;
    logic [1:0]  disp_ch     = 2'd0;
    logic        lap_ready   = 1'b0;

    logic [4:0]  aHours, bHours;
    logic [5:0]  aMin, bMin, aSec, bSec;
    logic [6:0]  aCs, bCs;
    logic [3:0]  aExpired, bExpired;
    logic        aLapValid, bLapValid, aOverflow, bOverflow;
    logic [1:0]  aLapCh, bLapCh;
    logic [23:0] aLapCs, bLapCs;

    int testCount = 0;
    int failCount = 0;

    always #5 clockSignal = ~clockSignal;

    lap_timer_bank #(.CHANNELS(4), .LAP_DEPTH(4), .TICK_DIV(1)) dutA (
        .clockSignal(clockSignal), .startOrStop(startOrStop),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ch(cmd_ch),
        .load_cs(load_cs), .load_down(load_down), .disp_ch(disp_ch),
        .disp_hours(aHours), .disp_min(aMin), .disp_sec(aSec), .disp_cs(aCs),
        .expired(aExpired), .lap_valid(aLapValid), .lap_ch(aLapCh), .lap_cs(aLapCs),
        .lap_ready(lap_ready), .lap_overflow(aOverflow)
    );

    lap_timer_bank #(.CHANNELS(4), .LAP_DEPTH(4), .TICK_DIV(3)) dutB (
        .clockSignal(clockSignal), .startOrStop(startOrStop),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ch(cmd_ch),
        .load_cs(load_cs), .load_down(load_down), .disp_ch(disp_ch),
        .disp_hours(bHours), .disp_min(bMin), .disp_sec(bSec), .disp_cs(bCs),
        .expired(bExpired), .lap_valid(bLapValid), .lap_ch(bLapCh), .lap_cs(bLapCs),
        .lap_ready(lap_ready), .lap_overflow(bOverflow)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dispA();
        return 32'(aHours) * 360000 + 32'(aMin) * 6000 + 32'(aSec) * 100 + 32'(aCs);
    endfunction

    function automatic logic [31:0] dispB();
        return 32'(bHours) * 360000 + 32'(bMin) * 6000 + 32'(bSec) * 100 + 32'(bCs);
    endfunction

    task automatic step();
        @(posedge clockSignal);
        #1;
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [1:0] ch,
                          input logic [23:0] value, input logic down);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ch    = ch;
        load_cs   = value;
        load_down = down;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        step();
        step();
        check_val("rst_disp", dispA(), 0);
        check_val("rst_expired", 32'(aExpired), 0);
        check_val("rst_lap_valid", 32'(aLapValid), 0);
        check_val("rst_overflow", 32'(aOverflow), 0);
        startOrStop = 1'b0;

        // prescaler phase: both DUTs count ch0 up from 0
        do_cmd(3'd0, 2'd0, 24'd0, 1'b0);
        do_cmd(3'd1, 2'd0, 24'd0, 1'b0);
        step();
        step();
        check_val("a_up_e4", dispA(), 1);
        check_val("b_up_e4", dispB(), 1);
        step();
        step();
        check_val("b_up_e6", dispB(), 1);
        step();
        check_val("a_up_e7", dispA(), 4);
        check_val("b_up_e7", dispB(), 2);

        // countdown expiry on ch0
        do_cmd(3'd0, 2'd0, 24'd5, 1'b1);
        do_cmd(3'd1, 2'd0, 24'd0, 1'b0);
        repeat (4) step();
        check_val("cd_not_yet", 32'(aExpired), 0);
        step();
        check_val("cd_expired", 32'(aExpired), 1);
        step();
        step();
        check_val("cd_hold_zero", dispA(), 0);

        // count-up wrap on ch1
        disp_ch = 2'd1;
        do_cmd(3'd0, 2'd1, 24'd8639998, 1'b0);
        do_cmd(3'd1, 2'd1, 24'd0, 1'b0);
        step();
        step();
        check_val("wrap_max_h", 32'(aHours), 23);
        check_val("wrap_max_m", 32'(aMin), 59);
        check_val("wrap_max_s", 32'(aSec), 59);
        check_val("wrap_max_cs", 32'(aCs), 99);
        step();
        check_val("wrap_zero", dispA(), 0);
        step();
        check_val("wrap_still_run", dispA(), 1);

        // lap FIFO fill, overflow and drain on ch2
        do_cmd(3'd0, 2'd2, 24'd0, 1'b0);
        do_cmd(3'd1, 2'd2, 24'd0, 1'b0);
        check_val("lap_empty", 32'(aLapValid), 0);
        for (int i = 0; i < 5; i++) begin
            do_cmd(3'd3, 2'd2, 24'd0, 1'b0);
            if (i == 0) check_val("lap_fwft", 32'(aLapValid), 1);
            if (i == 3) check_val("lap_no_ovf_yet", 32'(aOverflow), 0);
            step();
        end
        check_val("lap_overflow", 32'(aOverflow), 1);
        lap_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_val("drain_valid", 32'(aLapValid), 1);
            check_val("drain_ch", 32'(aLapCh), 2);
            check_val("drain_cs", 32'(aLapCs), 32'(k));
            step();
        end
        check_val("drain_done", 32'(aLapValid), 0);
        lap_ready = 1'b0;

        // LOAD colliding with a tick on running ch3
        do_cmd(3'd0, 2'd3, 24'd200, 1'b1);
        do_cmd(3'd1, 2'd3, 24'd0, 1'b0);
        step();
        do_cmd(3'd0, 2'd3, 24'd100, 1'b1);
        disp_ch = 2'd3;
        step();
        check_val("collide_load", dispA(), 100);
        step();
        check_val("collide_hold", dispA(), 100);

        // display decomposition and load clamp
        do_cmd(3'd0, 2'd3, 24'd366101, 1'b0);
        step();
        check_val("disp_h", 32'(aHours), 1);
        check_val("disp_m", 32'(aMin), 1);
        check_val("disp_s", 32'(aSec), 1);
        check_val("disp_cs", 32'(aCs), 1);
        do_cmd(3'd0, 2'd3, 24'hFFFFFF, 1'b0);
        step();
        check_val("clamp", dispA(), 8639999);

        // countdown START from zero expires without a tick
        do_cmd(3'd0, 2'd3, 24'd0, 1'b1);
        do_cmd(3'd1, 2'd3, 24'd0, 1'b0);
        check_val("zero_start_run", 32'(aExpired), 4'b0001);
        step();
        check_val("zero_start_done", 32'(aExpired), 4'b1001);

        // asynchronous reset with channels running and FIFO non-empty
        do_cmd(3'd0, 2'd0, 24'd1000, 1'b0);
        do_cmd(3'd1, 2'd0, 24'd0, 1'b0);
        do_cmd(3'd3, 2'd1, 24'd0, 1'b0);
        check_val("pre_rst_lap", 32'(aLapValid), 1);
        #3;
        startOrStop = 1'b1;
        #1;
        check_val("arst_lap_valid", 32'(aLapValid), 0);
        check_val("arst_lap_cs", 32'(aLapCs), 0);
        check_val("arst_expired", 32'(aExpired), 0);
        check_val("arst_overflow", 32'(aOverflow), 0);
        check_val("arst_disp", dispA(), 0);
        step();
        startOrStop = 1'b0;
        disp_ch = 2'd1;
        step();
        step();
        check_val("post_rst_idle", dispA(), 0);
        check_val("post_rst_lap", 32'(aLapValid), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
